keypad_scanner: RTL and testbench

//  Input-side counterpart of the seven-segment display multiplexer: drives a
//  4x4 matrix keypad one column at a time (one-cold), reads the active-low

---
 rtl/keypad_scanner_if.sv | 28 ++
 rtl/keypad_scanner.sv | 177 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: timebase tick, matrix rows/columns and the
// decoded key outputs. The scanner is the slave; board/consumer logic is the master.
interface keypad_scanner_if;
  logic       ce1ms;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key;
  logic       key_valid;
  logic       key_down;

  modport master (
    output ce1ms,
    output row_n,
    input  col_n,
    input  key,
    input  key_valid,
    input  key_down
  );

  modport slave (
    input  ce1ms,
    input  row_n,
    output col_n,
    output key,
    output key_valid,
    output key_down
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with ce1ms-based press/release debounce.
// Optional auto-repeat of key_valid while held: define KEYPAD_SCAN_REPEAT_EN.
//
// state       | meaning
// SCAN        | drive one column, sample rows on its last settle cycle
// DEB_PRESS   | latched row must stay low for DEBOUNCE_MS ticks
// PRESSED     | key accepted, watching the latched row for release
// DEB_RELEASE | latched row must stay high for DEBOUNCE_MS ticks
module keypad_scanner #(
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic              clk_i,
  input  logic              rst_i,
  keypad_scanner_if.slave   kp
);

  localparam int MS_MAX_A = (DEBOUNCE_MS > REPEAT_DELAY_MS) ? DEBOUNCE_MS : REPEAT_DELAY_MS;
  localparam int MS_MAX   = (MS_MAX_A > REPEAT_RATE_MS) ? MS_MAX_A : REPEAT_RATE_MS;
  localparam int CNT_W    = $clog2(MS_MAX + 1);
  localparam int SET_W    = $clog2(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_e;

  state_e           state_q;
  logic [3:0]       row_s1_q;
  logic [3:0]       row_s2_q;
  logic [1:0]       col_q;
  logic [1:0]       row_sel_q;
  logic [SET_W-1:0] settle_q;
  logic [CNT_W-1:0] ms_q;
  logic [3:0]       col_n_q;
  logic [3:0]       key_q;
  logic             key_valid_q;
  logic             key_down_q;

  logic [1:0]       col_d;
  logic [1:0]       low_row;
  logic             any_low;
  logic             row_high;

`ifdef KEYPAD_SCAN_REPEAT_EN
  logic [CNT_W-1:0] rep_q;
  logic             rep_first_q;
  logic [CNT_W-1:0] rep_target;

  assign rep_target = rep_first_q ? CNT_W'(REPEAT_DELAY_MS - 1) : CNT_W'(REPEAT_RATE_MS - 1);
`endif

  assign col_d    = col_q + 2'd1;
  assign any_low  = ~&row_s2_q;
  assign row_high = row_s2_q[row_sel_q];

  // Lowest-numbered low row wins when several keys share the column.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s2_q[i]) low_row = 2'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= SCAN;
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      col_q       <= 2'd0;
      row_sel_q   <= 2'd0;
      settle_q    <= '0;
      ms_q        <= '0;
      col_n_q     <= 4'b1110;
      key_q       <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
      rep_q       <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      row_s1_q    <= kp.row_n;
      row_s2_q    <= row_s1_q;
      key_valid_q <= 1'b0;

      case (state_q)
        SCAN: begin
          if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
            settle_q <= '0;
            if (any_low) begin
              row_sel_q <= low_row;
              ms_q      <= '0;
              state_q   <= DEB_PRESS;
            end else begin
              col_q   <= col_d;
              col_n_q <= ~(4'b0001 << col_d);
            end
          end else begin
            settle_q <= settle_q + SET_W'(1);
          end
        end

        // A row change beats a coincident tick: it is checked first.
        DEB_PRESS: begin
          if (row_high) begin
            ms_q    <= '0;
            col_q   <= col_d;
            col_n_q <= ~(4'b0001 << col_d);
            state_q <= SCAN;
          end else if (kp.ce1ms) begin
            if (ms_q == CNT_W'(DEBOUNCE_MS - 1)) begin
              ms_q        <= '0;
              key_q       <= {row_sel_q, col_q};
              key_valid_q <= 1'b1;
              key_down_q  <= 1'b1;
              state_q     <= PRESSED;
`ifdef KEYPAD_SCAN_REPEAT_EN
              rep_q       <= '0;
              rep_first_q <= 1'b1;
`endif
            end else begin
              ms_q <= ms_q + CNT_W'(1);
            end
          end
        end

        PRESSED: begin
          if (row_high) begin
            ms_q    <= '0;
            state_q <= DEB_RELEASE;
`ifdef KEYPAD_SCAN_REPEAT_EN
            rep_q   <= '0;
          end else if (kp.ce1ms) begin
            if (rep_q == rep_target) begin
              rep_q       <= '0;
              rep_first_q <= 1'b0;
              key_valid_q <= 1'b1;
            end else begin
              rep_q <= rep_q + CNT_W'(1);
            end
`endif
          end
        end

        DEB_RELEASE: begin
          if (!row_high) begin
            ms_q    <= '0;
            state_q <= PRESSED;
          end else if (kp.ce1ms) begin
            if (ms_q == CNT_W'(DEBOUNCE_MS - 1)) begin
              ms_q       <= '0;
              key_down_q <= 1'b0;
              col_q      <= col_d;
              col_n_q    <= ~(4'b0001 << col_d);
              state_q    <= SCAN;
            end else begin
              ms_q <= ms_q + CNT_W'(1);
            end
          end
        end

        default: state_q <= SCAN;
      endcase
    end
  end

  assign kp.col_n     = col_n_q;
  assign kp.key       = key_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: emulated key matrix, per-cycle
// behavioural model, directed scenarios and randomized press/bounce sessions.
module tb_keypad_scanner;
  localparam int SETTLE  = 4;
  localparam int DEB     = 20;
  localparam int RDELAY  = 500;
  localparam int RRATE   = 100;
  localparam int MS_CLKS = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0;
  int          checks = 0;
  int          errors = 0;
  int          kv_cnt = 0;
  int          last_key = -1;
  bit          live = 0;

  keypad_scanner_if kp();

  keypad_scanner #(
    .SETTLE_CYCLES  (SETTLE),
    .DEBOUNCE_MS    (DEB),
    .REPEAT_DELAY_MS(RDELAY),
    .REPEAT_RATE_MS (RRATE)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .kp   (kp)
  );

  always #5 clk = ~clk;

  // Key at bit r*4+c pulls row r low while column c is driven low.
  always_comb begin
    kp.row_n = 4'hF;
    for (int r = 0; r < 4; r++) kp.row_n[r] = ~|(keys[r*4 +: 4] & ~kp.col_n);
  end

  initial begin
    kp.ce1ms = 1'b0;
    forever begin
      repeat (MS_CLKS - 1) @(posedge clk);
      #2 kp.ce1ms = 1'b1;
      @(posedge clk);
      #2 kp.ce1ms = 1'b0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: what the outputs must be after the next clock edge.
  logic [3:0] m_s1, m_s2;
  int m_col, m_tcnt, m_watch, m_ms, m_code;
  bit m_held, m_rel;
  int m_key;
  bit m_kv, m_kd;
`ifdef KEYPAD_SCAN_REPEAT_EN
  int m_rep;
  bit m_rep_first;
`endif

  task automatic leave_to_next_column();
    m_watch = -1;
    m_held  = 0;
    m_rel   = 0;
    m_ms    = 0;
    m_tcnt  = 0;
    m_col   = (m_col + 1) % 4;
  endtask

  task automatic model_step(input bit rs, input bit ce, input logic [3:0] rn);
    bit low;
    if (rs) begin
      m_s1 = 4'hF; m_s2 = 4'hF;
      m_col = 0; m_tcnt = 0; m_watch = -1; m_ms = 0; m_code = 0;
      m_held = 0; m_rel = 0; m_key = 0; m_kv = 0; m_kd = 0;
`ifdef KEYPAD_SCAN_REPEAT_EN
      m_rep = 0; m_rep_first = 1;
`endif
      return;
    end
    m_kv = 0;
    if (m_watch < 0) begin
      if (m_tcnt == SETTLE - 1) begin
        m_tcnt = 0;
        if (m_s2 != 4'hF) begin
          m_watch = 0;
          while (m_s2[m_watch]) m_watch++;
          m_code = m_watch * 4 + m_col;
          m_ms = 0;
        end else begin
          m_col = (m_col + 1) % 4;
        end
      end else begin
        m_tcnt++;
      end
    end else begin
      low = !m_s2[m_watch];
      if (!m_held) begin
        if (!low) leave_to_next_column();
        else if (ce) begin
          m_ms++;
          if (m_ms == DEB) begin
            m_key = m_code; m_kv = 1; m_kd = 1; m_held = 1; m_ms = 0;
`ifdef KEYPAD_SCAN_REPEAT_EN
            m_rep = 0; m_rep_first = 1;
`endif
          end
        end
      end else if (!m_rel) begin
        if (!low) begin
          m_rel = 1; m_ms = 0;
`ifdef KEYPAD_SCAN_REPEAT_EN
          m_rep = 0;
        end else if (ce) begin
          m_rep++;
          if (m_rep == (m_rep_first ? RDELAY : RRATE)) begin
            m_kv = 1; m_rep = 0; m_rep_first = 0;
          end
`endif
        end
      end else begin
        if (low) begin
          m_rel = 0; m_ms = 0;
        end else if (ce) begin
          m_ms++;
          if (m_ms == DEB) begin
            m_kd = 0;
            leave_to_next_column();
          end
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = rn;
  endtask

  always @(negedge clk) begin
    logic [3:0] exp_col;
    if (live) begin
      exp_col = 4'hF;
      exp_col[m_col] = 1'b0;
      chk("model col_n", int'(kp.col_n), int'(exp_col));
      chk("model key", int'(kp.key), m_key);
      chk("model key_valid", int'(kp.key_valid), int'(m_kv));
      chk("model key_down", int'(kp.key_down), int'(m_kd));
    end
    model_step(rst, kp.ce1ms, kp.row_n);
    if (rst) live = 1;
  end

  always @(negedge clk) begin
    if (!rst && kp.key_valid === 1'b1) begin
      kv_cnt++;
      last_key = int'(kp.key);
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic ms(input int n);
    clks(n * MS_CLKS);
  endtask

  task automatic wait_kd_low(input string nm, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (kp.key_down == 1'b0) begin
        ok = 1;
        break;
      end
    end
    chk({nm, " key_down release timeout"}, int'(ok), 1);
  endtask

  initial begin
    logic [3:0] pat [5];
    int base;
    pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111; pat[4] = 4'b1110;

    // Reset and idle column rotation
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset col_n", int'(kp.col_n), 14);
    chk("reset key", int'(kp.key), 0);
    chk("reset key_valid", int'(kp.key_valid), 0);
    chk("reset key_down", int'(kp.key_down), 0);
    for (int i = 1; i < 5; i++) begin
      repeat (4) @(negedge clk);
      chk("idle scan col_n", int'(kp.col_n), int'(pat[i]));
    end

    // Clean press of row 2 / column 1
    clks(1);
    base = kv_cnt;
    keys = 16'(1 << 9);
    ms(40);
    @(negedge clk);
    chk("clean press key_down", int'(kp.key_down), 1);
    clks(1);
    keys = '0;
    wait_kd_low("clean press", 40 * MS_CLKS);
    chk("scan resumes col_n", int'(kp.col_n), 4'b1011);
    chk("clean press pulses", kv_cnt - base, 1);
    chk("clean press key", last_key, 9);
    ms(5);

    // Bouncing contact then steady; then a too-short press
    base = kv_cnt;
    for (int i = 0; i < 5; i++) begin
      keys = (i % 2 == 0) ? 16'(1 << 5) : 16'h0;
      ms(3);
    end
    keys = 16'(1 << 5);
    ms(40);
    keys = '0;
    ms(30);
    chk("bounce single pulse", kv_cnt - base, 1);
    base = kv_cnt;
    keys = 16'(1 << 5);
    ms(5);
    keys = '0;
    ms(30);
    chk("short press no pulse", kv_cnt - base, 0);

    // Two keys in column 0, release the lower row
    base = kv_cnt;
    keys = 16'((1 << 4) | (1 << 12));
    ms(30);
    chk("two keys low row wins", last_key, 4);
    chk("two keys one pulse", kv_cnt - base, 1);
    keys = 16'(1 << 12);
    wait_kd_low("partial release", 40 * MS_CLKS);
    ms(30);
    chk("row 3 re-detected", last_key, 12);
    chk("row 3 pulse", kv_cnt - base, 2);
    keys = '0;
    ms(30);

    // Reset while a key is held
    keys = 16'(1 << 6);
    ms(25);
    @(negedge clk);
    chk("pre-reset key_down", int'(kp.key_down), 1);
    base = kv_cnt;
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("mid-press reset col_n", int'(kp.col_n), 14);
    chk("mid-press reset key_down", int'(kp.key_down), 0);
    chk("mid-press reset key", int'(kp.key), 0);
    clks(1);
    ms(30);
    chk("re-accept after reset", kv_cnt - base, 1);
    chk("re-accept key", last_key, 6);
    keys = '0;
    ms(30);

    // Long hold: auto-repeat only when enabled
    base = kv_cnt;
    keys = 16'(1 << 3);
    ms(800);
    keys = '0;
    ms(30);
`ifdef KEYPAD_SCAN_REPEAT_EN
    chk("long hold pulses", kv_cnt - base, 4);
`else
    chk("long hold pulses", kv_cnt - base, 1);
`endif

    // Randomized sessions with bounce and overlapping keys
    for (int it = 0; it < 20; it++) begin
      logic [15:0] k;
      k = 16'(1 << $urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) k = k | 16'(1 << $urandom_range(0, 15));
      for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
        keys = k;
        clks($urandom_range(5, 40));
        keys = '0;
        clks($urandom_range(5, 40));
      end
      keys = k;
      clks($urandom_range(10, 500));
      keys = ($urandom_range(0, 3) == 0) ? (k & 16'(1 << $urandom_range(0, 15))) : 16'h0;
      clks($urandom_range(10, 200));
      keys = '0;
      clks($urandom_range(10, 300));
    end

    clks(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
